// File: rtl/mem_stage_hs.sv
// Memory pipeline stage with a fixed-latency handshake to the data memory and a MEM/WB register.
// Aligned loads/stores occupy LAT+1 cycles, stalling IF..M; misaligned accesses complete at once.
module mem_stage_hs #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned LAT   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteM,
   input  logic        LoadM,
   input  logic        StoreM,
   input  logic [2:0]  Funct3M,
   input  logic [1:0]  ResultSrcM,
   input  logic [4:0]  RD_M,
   input  logic [31:0] PCPlus4M,
   input  logic [31:0] ALU_ResultM,
   input  logic [31:0] WriteDataM,
   input  logic        FlushW,
   output logic        RegWriteW,
   output logic [1:0]  ResultSrcW,
   output logic [4:0]  RD_W,
   output logic [31:0] PCPlus4W,
   output logic [31:0] ALU_ResultW,
   output logic [31:0] ReadDataW,
   output logic        StallM,
   output logic        MisalignW
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic {StIdle, StBusy} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] mem [DEPTH];

   logic          access, is_load, is_store, misalign, bad_acc, complete, stall, mem_we;
   logic [AW-1:0] idx;
   logic [1:0]    off;
   logic [31:0]   rword, wdata, ext_data, load_val;
   logic [7:0]    rbyte;
   logic [15:0]   rhalf;
   logic [3:0]    wmask;
   logic          unused_addr;

   logic        regwrite_q, misalign_q;
   logic [1:0]  resultsrc_q;
   logic [4:0]  rd_q;
   logic [31:0] pcplus4_q, aluresult_q, readdata_q;

   assign access      = LoadM | StoreM;
   assign is_store    = StoreM;
   assign is_load     = LoadM & ~StoreM;
   assign idx         = ALU_ResultM[AW+1:2];
   assign off         = ALU_ResultM[1:0];
   assign unused_addr = ^ALU_ResultM[31:AW+2];

   // Reserved encodings 011/110/111 fall into the word branch.
   always_comb begin
      misalign = 1'b0;
      unique case (Funct3M[1:0])
         2'b00:   misalign = 1'b0;
         2'b01:   misalign = off[0];
         default: misalign = (off != 2'b00);
      endcase
   end

   assign bad_acc = access & misalign;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      stall    = 1'b0;
      complete = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (access && !misalign && (LAT != 0)) begin
               stall   = 1'b1;
               state_d = StBusy;
               cnt_d   = 4'(LAT - 1);
            end else begin
               complete = 1'b1;
            end
         end
         StBusy: begin
            if (cnt_q != 4'd0) begin
               stall = 1'b1;
               cnt_d = cnt_q - 4'd1;
            end else begin
               complete = 1'b1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Reset masks the stall combinationally so the pipeline is released at once.
   assign StallM = stall & rst;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      wdata = WriteDataM;
      wmask = 4'b1111;
      unique case (Funct3M[1:0])
         2'b00: begin
            wdata = {4{WriteDataM[7:0]}};
            wmask = 4'b0001 << off;
         end
         2'b01: begin
            wdata = {2{WriteDataM[15:0]}};
            wmask = off[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            wdata = WriteDataM;
            wmask = 4'b1111;
         end
      endcase
   end

   assign mem_we = complete & is_store & ~misalign & rst;

   // Data array has no reset; contents survive rst.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (wmask[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rword = mem[idx];
   assign rhalf = off[1] ? rword[31:16] : rword[15:0];

   always_comb begin
      rbyte = rword[7:0];
      unique case (off)
         2'd0: rbyte = rword[7:0];
         2'd1: rbyte = rword[15:8];
         2'd2: rbyte = rword[23:16];
         2'd3: rbyte = rword[31:24];
         default: rbyte = rword[7:0];
      endcase
   end

   always_comb begin
      unique case (Funct3M)
         3'b000:  ext_data = {{24{rbyte[7]}}, rbyte};
         3'b100:  ext_data = {24'd0, rbyte};
         3'b001:  ext_data = {{16{rhalf[15]}}, rhalf};
         3'b101:  ext_data = {16'd0, rhalf};
         default: ext_data = rword;
      endcase
   end

   assign load_val = (is_load && !misalign) ? ext_data : 32'd0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         regwrite_q  <= 1'b0;
         resultsrc_q <= 2'd0;
         rd_q        <= 5'd0;
         pcplus4_q   <= 32'd0;
         aluresult_q <= 32'd0;
         readdata_q  <= 32'd0;
         misalign_q  <= 1'b0;
      end else if (FlushW || !complete) begin
         regwrite_q  <= 1'b0;
         resultsrc_q <= 2'd0;
         rd_q        <= 5'd0;
         pcplus4_q   <= 32'd0;
         aluresult_q <= 32'd0;
         readdata_q  <= 32'd0;
         misalign_q  <= 1'b0;
      end else begin
         regwrite_q  <= RegWriteM & ~bad_acc;
         resultsrc_q <= ResultSrcM;
         rd_q        <= RD_M;
         pcplus4_q   <= PCPlus4M;
         aluresult_q <= ALU_ResultM;
         readdata_q  <= load_val;
         misalign_q  <= bad_acc;
      end
   end

   assign RegWriteW   = regwrite_q;
   assign ResultSrcW  = resultsrc_q;
   assign RD_W        = rd_q;
   assign PCPlus4W    = pcplus4_q;
   assign ALU_ResultW = aluresult_q;
   assign ReadDataW   = readdata_q;
   assign MisalignW   = misalign_q;

endmodule
